// File: rtl/config_reg_bank.sv
// ============================================================================
// config_reg_bank
// ----------------------------------------------------------------------------
// Double-buffered configuration register bank. Writes land in a shadow copy.
// A commit pulse copies every shadow register into the active copy, and only
// the active copy drives cfg_out and read data. A sticky lock blocks all
// further writes until reset. A rejected write gets a one-cycle wr_err pulse.
//
// Optional feature macro: CFG_PARITY_EN
//   defined   : each active register carries an even-parity bit. It is
//               computed at commit/reset. par_inject together with commit
//               stores inverted parity. Any mismatch sets a sticky par_err.
//   undefined : no parity storage, par_err is tied low, par_inject is ignored.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-low reset
//   wr_valid   in   write request
//   wr_ready   out  write accept (low in reset and the first cycle after it)
//   address    in   write address
//   data_in    in   write data
//   commit     in   copy all shadow registers to active
//   lock       in   set sticky lock
//   rd_en      in   read request
//   rd_addr    in   read address
//   data_out   out  read data, valid with rd_valid
//   rd_valid   out  read data valid, one cycle after rd_en
//   wr_err     out  one-cycle pulse after a rejected write
//   locked     out  sticky lock status
//   cfg_out    out  active register image, reg0 in the LSBs
//   par_inject in   parity fault injection
//   par_err    out  sticky parity error
// ============================================================================
module config_reg_bank #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 4,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS =
    {16'h0001, 16'h0000, 16'h0000, 16'hABCD,
     16'h0000, 16'h0000, 16'h0000, 16'hFFFF}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       commit,
  input  logic                       lock,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_valid,
  output logic                       wr_err,
  output logic                       locked,
  output logic [NUM_REGS*DATA_W-1:0] cfg_out,
  input  logic                       par_inject,
  output logic                       par_err
);

  // Register count widened by one bit so the range check cannot overflow.
  localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_shadow;
  logic [NUM_REGS-1:0][DATA_W-1:0] r_active;
  logic                            r_wr_ready;
  logic                            r_wr_err;
  logic                            r_locked;
  logic                            r_rd_valid;
  logic [DATA_W-1:0]               r_data_out;

  logic                            w_wr_acc;
  logic                            w_wr_in_range;
  logic                            w_wr_ok;
  logic                            w_wr_rej;
  logic [NUM_REGS-1:0]             w_wr_sel;
  logic [DATA_W-1:0]               w_rd_data;

  // Write acceptance and rejection classification.
  always_comb begin
    w_wr_acc      = wr_valid & r_wr_ready;
    w_wr_in_range = ({1'b0, address} < LP_NUM_REGS);
    // The lock is sampled before the edge, so a write on the lock edge still lands.
    w_wr_ok       = w_wr_acc & w_wr_in_range & ~r_locked;
    w_wr_rej      = w_wr_acc & (~w_wr_in_range | r_locked);
  end

  // Write one-hot decode and read mux. An out-of-range read address matches
  // no register, so it yields all zeros.
  always_comb begin
    w_wr_sel  = {NUM_REGS{1'b0}};
    w_rd_data = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      w_wr_sel[i] = w_wr_ok & (address == ADDR_W'(i));
      w_rd_data   = w_rd_data |
                    ((rd_addr == ADDR_W'(i)) ? r_active[i] : {DATA_W{1'b0}});
    end
  end

  // Shadow registers: written by accepted, in-range, unlocked writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= RESET_VALS;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_sel[i]) begin
          r_shadow[i] <= data_in;
        end
      end
    end
  end

  // Active registers: commit copies the shadow values as they were before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= RESET_VALS;
    end else if (commit) begin
      r_active <= r_shadow;
    end
  end

  // Write handshake, error pulse and sticky lock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ready <= 1'b0;
      r_wr_err   <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_wr_ready <= 1'b1;
      r_wr_err   <= w_wr_rej;
      r_locked   <= r_locked | lock;
    end
  end

  // Read pipeline: one cycle of latency. data_out holds its value between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_valid <= 1'b0;
      r_data_out <= {DATA_W{1'b0}};
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_data_out <= w_rd_data;
      end
    end
  end

  assign wr_ready = r_wr_ready;
  assign wr_err   = r_wr_err;
  assign locked   = r_locked;
  assign rd_valid = r_rd_valid;
  assign data_out = r_data_out;
  assign cfg_out  = r_active;

`ifdef CFG_PARITY_EN
  logic [NUM_REGS-1:0] r_par;
  logic                r_par_err;
  logic                w_par_mismatch;

  // Even parity bit: makes the total count of ones, parity bit included, even.
  function automatic logic f_even_par(input logic [DATA_W-1:0] d);
    f_even_par = ^d;
  endfunction

  // Parity storage for the active copy. Injection inverts every stored bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_par[i] <= f_even_par(RESET_VALS[i*DATA_W +: DATA_W]);
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_par[i] <= f_even_par(r_shadow[i]) ^ par_inject;
      end
    end
  end

  // Continuous check of the stored active values against their parity bits.
  always_comb begin
    w_par_mismatch = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_par_mismatch = w_par_mismatch | (f_even_par(r_active[i]) ^ r_par[i]);
    end
  end

  // Sticky error flag. An injected commit is flagged at the commit edge
  // itself, so the error shows in the very next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= r_par_err | w_par_mismatch | (commit & par_inject);
    end
  end

  assign par_err = r_par_err;
`else
  logic w_unused_par_inject;
  assign w_unused_par_inject = par_inject;
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_config_reg_bank.sv
// Self-checking bench for config_reg_bank with a scoreboard. The driver updates
// a behavioural array model and queues the expected responses. A monitor on
// the falling clock edge pops each entry and compares it with the DUT outputs.
module tb_config_reg_bank;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 4;
  localparam logic [NR*DW-1:0] RV =
    {16'h0001, 16'h0000, 16'h0000, 16'hABCD,
     16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
  localparam logic [15:0] RST_TAB [NR] =
    '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
      16'hABCD, 16'h0000, 16'h0000, 16'h0001};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_valid = 1'b0, commit = 1'b0, lock = 1'b0, rd_en = 1'b0, par_inject = 1'b0;
  logic [AW-1:0] address = '0, rd_addr = '0;
  logic [DW-1:0] data_in = '0;
  logic wr_ready, rd_valid, wr_err, locked, par_err;
  logic [DW-1:0] data_out;
  logic [NR*DW-1:0] cfg_out;

  config_reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RESET_VALS(RV)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .address(address), .data_in(data_in), .commit(commit), .lock(lock),
    .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out), .rd_valid(rd_valid),
    .wr_err(wr_err), .locked(locked), .cfg_out(cfg_out),
    .par_inject(par_inject), .par_err(par_err));

  always #5 clk = ~clk;

  typedef struct { int due; logic [DW-1:0] d; } rd_exp_t;
  typedef struct { int due; logic err; logic lck; logic perr; logic rdy; logic [NR*DW-1:0] cfg; } st_exp_t;

  rd_exp_t rd_q[$];
  st_exp_t st_q[$];
  int edge_cnt = 0;
  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  logic [DW-1:0] m_shadow [NR];
  logic [DW-1:0] m_active [NR];
  logic m_locked, m_ready, m_perr;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [NR*DW-1:0] pack_active();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_active[i];
    return v;
  endfunction

  // Monitor
  logic [DW-1:0] last_data = '0;
  st_exp_t s_m;
  rd_exp_t r_m;
  always @(negedge clk) begin
    if (!reset) begin
      last_data = '0;
    end else begin
      if (st_q.size() > 0 && st_q[0].due == edge_cnt) begin
        s_m = st_q.pop_front();
        n_chk++;
        if ({wr_err, locked, par_err, wr_ready, cfg_out} !== {s_m.err, s_m.lck, s_m.perr, s_m.rdy, s_m.cfg}) begin
          n_err++;
          $display("FAIL status edge=%0d got err=%b lck=%b perr=%b rdy=%b cfg=%h want err=%b lck=%b perr=%b rdy=%b cfg=%h",
                   edge_cnt, wr_err, locked, par_err, wr_ready, cfg_out,
                   s_m.err, s_m.lck, s_m.perr, s_m.rdy, s_m.cfg);
        end
      end
      if (rd_valid === 1'b1) begin
        n_chk++;
        if (rd_q.size() == 0 || rd_q[0].due != edge_cnt) begin
          n_err++;
          $display("FAIL rd_unexpected edge=%0d got rd_valid=1 data=%h want rd_valid=0", edge_cnt, data_out);
        end else begin
          r_m = rd_q.pop_front();
          if (data_out !== r_m.d) begin
            n_err++;
            $display("FAIL rd_data edge=%0d got %h want %h", edge_cnt, data_out, r_m.d);
          end
        end
        last_data = data_out;
      end else begin
        n_chk++;
        if (rd_q.size() > 0 && rd_q[0].due == edge_cnt) begin
          r_m = rd_q.pop_front();
          n_err++;
          $display("FAIL rd_missing edge=%0d got rd_valid=%b want 1 data=%h", edge_cnt, rd_valid, r_m.d);
        end else if (data_out !== last_data) begin
          n_err++;
          $display("FAIL rd_hold edge=%0d got %h want %h", edge_cnt, data_out, last_data);
        end
      end
    end
  end

  task automatic step(input logic wv, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic cm, input logic lk, input logic re,
                      input logic [AW-1:0] ra, input logic inj);
    logic acc, rej;
    logic [DW-1:0] old_sh [NR];
    rd_exp_t r;
    st_exp_t s;
    wr_valid = wv; address = a; data_in = d; commit = cm; lock = lk;
    rd_en = re; rd_addr = ra; par_inject = inj;
    acc = wv && m_ready;
    rej = acc && ((a >= NR) || m_locked);
    if (re) begin
      r.due = edge_cnt + 1;
      r.d = (ra < NR) ? m_active[ra] : 16'h0000;
      rd_q.push_back(r);
    end
    old_sh = m_shadow;
    if (acc && !rej) m_shadow[a] = d;
    if (cm) m_active = old_sh;
    if (lk) m_locked = 1'b1;
`ifdef CFG_PARITY_EN
    if (cm && inj) m_perr = 1'b1;
`endif
    m_ready = 1'b1;
    s.due = edge_cnt + 1; s.err = rej; s.lck = m_locked; s.perr = m_perr;
    s.rdy = 1'b1; s.cfg = pack_active();
    st_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(); step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0); endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d); step(1'b1, a, d, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0); endtask
  task automatic rd(input logic [AW-1:0] a); step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, a, 1'b0); endtask
  task automatic cmt(); step(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0); endtask

  task automatic do_reset();
    reset = 1'b0;
    wr_valid = 1'b0; commit = 1'b0; lock = 1'b0; rd_en = 1'b0; par_inject = 1'b0;
    rd_q.delete();
    st_q.delete();
    for (int i = 0; i < NR; i++) begin
      m_shadow[i] = RST_TAB[i];
      m_active[i] = RST_TAB[i];
    end
    m_locked = 1'b0; m_ready = 1'b0; m_perr = 1'b0;
    #1;
    n_chk++;
    if ({rd_valid, wr_ready, wr_err, locked, par_err, data_out, cfg_out} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, pack_active()}) begin
      n_err++;
      $display("FAIL reset_state got rdv=%b rdy=%b err=%b lck=%b perr=%b dout=%h cfg=%h want all 0 cfg=%h",
               rd_valid, wr_ready, wr_err, locked, par_err, data_out, cfg_out, pack_active());
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();
    // Write into the first cycle after release must be ignored (wr_ready=0).
    wr(4'd3, 16'h1234);
    idle();
    cmt();
    rd(4'd3);
    // Shadow write invisible until commit
    wr(4'd6, 16'hABCD);
    rd(4'd6);
    cmt();
    rd(4'd6);
    // Write and commit on the same edge
    step(1'b1, 4'd6, 16'h5EAB, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    rd(4'd6);
    cmt();
    rd(4'd6);
    // Read and commit on the same edge returns the pre-commit value
    wr(4'd0, 16'h0F0F);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    rd(4'd0);
    // Lock, then rejected write; commit still works
    step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    wr(4'd1, 16'hFFFF);
    cmt();
    rd(4'd1);
    idle();
    do_reset();
    idle();
    // Out-of-range write and read while unlocked
    wr(4'd9, 16'h7777);
    rd(4'd9);
    rd(4'd15);
    // Lock and write on the same edge: the write is accepted
    step(1'b1, 4'd2, 16'h0001, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    rd(4'd2);
    do_reset();   // pending read response, uncommitted reg2 and lock all discarded
    idle();
    rd(4'd2);
    // Parity injection (par_err only rises when the feature is built in)
    step(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    idle();
    cmt();
    idle();
    do_reset();
    idle();
    // Randomized back-to-back traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 1) == 1),
             AW'($urandom_range(0, 11)),
             DW'($urandom),
             ($urandom_range(0, 6) == 0),
             ($urandom_range(0, 59) == 0),
             ($urandom_range(0, 1) == 1),
             AW'($urandom_range(0, 11)),
             ($urandom_range(0, 19) == 0));
      end
    end
    idle();
    wr_valid = 1'b0; commit = 1'b0; lock = 1'b0; rd_en = 1'b0; par_inject = 1'b0;
    for (int k = 0; k < 10 && (rd_q.size() > 0 || st_q.size() > 0); k++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (rd_q.size() > 0 || st_q.size() > 0) begin
      n_err++;
      $display("FAIL drain got rd_q=%0d st_q=%0d pending want 0", rd_q.size(), st_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/config_reg_bank.md
CONFIG_REG_BANK -- requirements
Module: config_reg_bank

Interface
REQ-001 Parameter DATA_W, default 16: register width in bits.
REQ-002 Parameter NUM_REGS, default 8: number of registers, legal 2..64.
REQ-003 Parameter ADDR_W, default 4: address width; SHALL satisfy 2**ADDR_W >= NUM_REGS.
REQ-004 Parameter RESET_VALS, default {16'h0001,16'h0000,16'h0000,16'hABCD,16'h0000,16'h0000,16'h0000,16'hFFFF}: NUM_REGS*DATA_W reset image; reg0 is the LSB slice (reg0=FFFF, reg4=ABCD, reg7=0001).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 wr_valid  in  1  write request.
REQ-008 wr_ready  out  1  write accept; a write is accepted on a clk edge with wr_valid && wr_ready.
REQ-009 address  in  ADDR_W  write address.
REQ-010 data_in  in  DATA_W  write data.
REQ-011 commit  in  1  pulse: copy all shadow registers to active registers.
REQ-012 lock  in  1  pulse: set sticky lock.
REQ-013 rd_en  in  1  read request.
REQ-014 rd_addr  in  ADDR_W  read address.
REQ-015 data_out  out  DATA_W  read data, valid when rd_valid=1.
REQ-016 rd_valid  out  1  read data valid.
REQ-017 wr_err  out  1  one-cycle pulse on rejected write.
REQ-018 locked  out  1  sticky lock status.
REQ-019 cfg_out  out  NUM_REGS*DATA_W  active register values, reg0 in LSBs.
REQ-020 par_inject  in  1  parity fault injection (used only with CFG_PARITY_EN).
REQ-021 par_err  out  1  sticky parity error.

Function
REQ-022 Each register SHALL have a shadow copy and an active copy; cfg_out SHALL drive active copies only.
REQ-023 Accepted write with address < NUM_REGS and locked=0 SHALL update shadow[address] at that edge; active unchanged.
REQ-024 Accepted write with address >= NUM_REGS or locked=1 SHALL change no state and SHALL pulse wr_err high for exactly the following cycle.
REQ-025 wr_ready SHALL be 0 in reset and the first cycle after reset release, then 1 permanently.
REQ-026 commit=1 SHALL copy every shadow to active at that edge; visible on cfg_out the next cycle (latency 1).
REQ-027 Write and commit on the same edge: commit copies pre-write shadow values; written value reaches active on the next commit.
REQ-028 commit SHALL take effect regardless of locked.
REQ-029 lock=1 SHALL set locked at that edge; cleared only by reset. Write and lock on same edge: write accepted (lock evaluated before the edge).
REQ-030 Read: rd_en=1 at edge N SHALL present active[rd_addr] on data_out with rd_valid=1 during cycle N+1; rd_addr >= NUM_REGS SHALL return all-zero with rd_valid=1.
REQ-031 rd_valid SHALL be 0 in any cycle not following an rd_en; data_out SHALL hold its last value when rd_valid=0.
REQ-032 Read and commit on same edge SHALL return pre-commit active value.
REQ-033 Back-to-back reads and writes SHALL sustain one per cycle each.

Reset
REQ-034 reset=0 SHALL asynchronously load shadow and active from RESET_VALS, clear locked, par_err, wr_err, rd_valid, wr_ready, data_out=0.
REQ-035 Reset asserted mid-operation SHALL discard any pending read response and uncommitted shadow data.

Configuration
REQ-036 Macro CFG_PARITY_EN defined: each active register SHALL hold an even-parity bit computed at commit/reset; par_inject=1 with commit SHALL store inverted parity for every register; any active register whose parity mismatches SHALL set par_err the next cycle, sticky until reset.
REQ-037 CFG_PARITY_EN undefined: no parity storage, par_err tied 0, par_inject ignored.

Verification
REQ-038 Release reset -> cfg_out reg0=FFFF, reg4=ABCD, reg7=0001, others 0000; wr_ready 1 from second cycle.
REQ-039 Write reg6=ABCD, read reg6 -> 0000; commit, read reg6 -> ABCD with rd_valid one cycle after rd_en.
REQ-040 Write reg6=5EAB same edge as commit -> reg6 active unchanged; next commit -> 5EAB.
REQ-041 Pulse lock, write reg1=FFFF -> wr_err pulse 1 cycle, commit leaves reg1=0000; write address 9 unlocked -> wr_err, read address 9 -> 0000.
REQ-042 Assert reset while reg2 shadow=0001 uncommitted and rd_en pending -> rd_valid 0, reg2 active 0000, locked 0.
REQ-043 CFG_PARITY_EN: commit with par_inject=1 -> par_err=1 next cycle, stays 1 until reset; without macro par_err stays 0.
